am2950_port: RTL and testbench
==============================

AM2950_PORT -- requirements
Module: am2950_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the data width of both ports and both registers.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port a, inout, WIDTH bits: A-side bidirectional data bus.
REQ-005 SHALL have port b, inout, WIDTH bits: B-side bidirectional data bus.
REQ-006 SHALL have port wra, input, 1 bit: write strobe that loads a into register RAB.
REQ-007 SHALL have port rdb, input, 1 bit: B-side read acknowledge that clears flag FAB.
REQ-008 SHALL have port wrb, input, 1 bit: write strobe that loads b into register RBA.
REQ-009 SHALL have port rda, input, 1 bit: A-side read acknowledge that clears flag FBA.
REQ-010 SHALL have port oea_, input, 1 bit, active-low: drives RBA onto a.
REQ-011 SHALL have port oeb_, input, 1 bit, active-low: drives RAB onto b.
REQ-012 SHALL have port fab, output, 1 bit: RAB holds unread data.
REQ-013 SHALL have port fba, output, 1 bit: RBA holds unread data.
REQ-014 SHALL have port ovr, output, 2 bits: sticky overrun flags; bit 0 for A-to-B, bit 1 for B-to-A.
REQ-015 SHALL have port clrov, input, 1 bit: synchronous clear of both overrun bits.

Function
REQ-016 SHALL, when oea_=1, wra=1 and FAB=0, load RAB with a and set FAB at the next clk rising edge.
REQ-017 SHALL ignore wra while oea_=0, so the port never captures its own driven value.
REQ-018 SHALL, when wra=1 with FAB=1 and rdb=0, leave RAB unchanged, keep FAB=1 and set ovr[0].
REQ-019 SHALL, when rdb=1 and wra is not accepted, clear FAB at the next edge; RAB keeps its value.
REQ-020 SHALL, when wra=1 and rdb=1 occur together with FAB=1, treat the read as first: RAB loads a, FAB stays 1, and ovr[0] does not change.
REQ-021 SHALL treat rdb=1 with FAB=0 as a no-op.
REQ-022 SHALL implement B-to-A handling (wrb, rda, RBA, FBA, ovr[1], oeb_ qualifier) exactly mirroring REQ-016 to REQ-021.
REQ-023 SHALL make each direction a two-state machine, EMPTY (flag=0) and FULL (flag=1), with the transitions given above.
REQ-024 SHALL drive b combinationally as RAB when oeb_=0 and high-Z otherwise.
REQ-025 SHALL drive a combinationally as RBA when oea_=0 and high-Z otherwise.
REQ-026 SHALL let the output enables operate independently of the flags; reading a register does not require it to be FULL.
REQ-027 SHALL make the flag outputs visible one cycle after the accepting edge, with no combinational path from strobes to flags.
REQ-028 SHALL clear both ovr bits when clrov=1; a same-edge overrun event takes priority and leaves its bit set.

Reset
REQ-029 SHALL, when rst_=0, immediately force RAB=0, RBA=0, fab=0, fba=0, ovr=00, independent of clk.
REQ-030 SHALL, when reset is asserted mid-transfer, discard any strobe in that cycle; after release, the first edge behaves as if from EMPTY.
REQ-031 SHALL keep the bus outputs governed only by oea_/oeb_ during reset, driving zeros when enabled.

Configuration
REQ-032 SHALL, when the macro AM2950_PORT_INT_EN is defined, add outputs inta_ and intb_ (active-low, 1 bit): inta_ = ~(fba | ovr[1]) and intb_ = ~(fab | ovr[0]).
REQ-033 SHALL, when AM2950_PORT_INT_EN is undefined, omit inta_ and intb_ and leave all other behaviour unchanged.

Verification
REQ-034 Bench SHALL cover: reset, then a=8'h5A with wra pulse and oeb_=0 -> fab=1 next cycle, b=8'h5A; rdb pulse -> fab=0 and b stays 8'h5A.
REQ-035 Bench SHALL cover: with FAB=1 holding 8'h11, wra with a=8'h22 -> RAB stays 8'h11, ovr=01; clrov -> ovr=00.
REQ-036 Bench SHALL cover: with FAB=1, wra and rdb on the same edge with a=8'h33 -> RAB=8'h33, fab=1, ovr=00.
REQ-037 Bench SHALL cover: b=8'hC3 with wrb while oeb_=1, then oea_=0 -> a=8'hC3, fba=1; wra asserted during oea_=0 -> ignored, fab=0.
REQ-038 Bench SHALL cover: rst_ pulsed low between clk edges while both registers are FULL -> flags, registers and ovr read 0 at once, a/b high-Z with enables off.
REQ-039 Bench SHALL cover, with AM2950_PORT_INT_EN defined: wrb load -> intb_ stays 1 and inta_=0; rda -> inta_=1.

Source files
------------

// File: rtl/am2950_port.sv
// am2950_port: bidirectional two-register mailbox between an A bus and a B bus.
//
// RAB carries data from A to B and RBA carries data from B to A. Each direction
// is a two-state machine: EMPTY (flag=0) and FULL (flag=1). fab/fba are the
// state bits of those machines and serve directly as their state outputs.
// Each direction also has a sticky overrun bit in ovr.
//
// Optional feature: define AM2950_PORT_INT_EN to add the active-low interrupt
// outputs inta_ and intb_. The default build (macro undefined) omits them.
//
// Handshake: a write strobe (wra/wrb) is accepted on a rising clk edge only
// while the port's own output driver is off (oea_=1 / oeb_=1). A read
// acknowledge (rda/rdb) empties the register, and a simultaneous accepted write
// is ordered after the read. A write into a FULL register without a read is
// refused and sets the overrun bit.
module am2950_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             wra,
  input  logic             rdb,
  input  logic             wrb,
  input  logic             rda,
  input  logic             oea_,
  input  logic             oeb_,
  output logic             fab,
  output logic             fba,
  output logic [1:0]       ovr,
  input  logic             clrov
`ifdef AM2950_PORT_INT_EN
  ,
  output logic             inta_,
  output logic             intb_
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } dir_state_t;

  dir_state_t ab_state, ab_next;
  dir_state_t ba_state, ba_next;

  logic [WIDTH-1:0] rab;
  logic [WIDTH-1:0] rba;
  logic [1:0]       ovr_q;

  // A port never captures a value that it is driving onto its own bus.
  logic wr_a_ok;
  logic wr_b_ok;
  assign wr_a_ok = wra & oea_;
  assign wr_b_ok = wrb & oeb_;

  logic load_rab;
  logic load_rba;
  logic ovr_ab_set;
  logic ovr_ba_set;

  // State register for both direction machines.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ab_state <= EMPTY;
      ba_state <= EMPTY;
    end else begin
      ab_state <= ab_next;
      ba_state <= ba_next;
    end
  end

  // Next-state logic: read first, then write; a refused write keeps FULL.
  always_comb begin
    ab_next = ab_state;
    case (ab_state)
      EMPTY: if (wr_a_ok) ab_next = FULL;
      FULL:  if (rdb && !wr_a_ok) ab_next = EMPTY;
    endcase
    ba_next = ba_state;
    case (ba_state)
      EMPTY: if (wr_b_ok) ba_next = FULL;
      FULL:  if (rda && !wr_b_ok) ba_next = EMPTY;
    endcase
  end

  // Output logic: register load enables and overrun events per state.
  always_comb begin
    load_rab   = 1'b0;
    ovr_ab_set = 1'b0;
    case (ab_state)
      EMPTY: load_rab = wr_a_ok;
      FULL: begin
        load_rab   = wr_a_ok & rdb;
        ovr_ab_set = wr_a_ok & ~rdb;
      end
    endcase
    load_rba   = 1'b0;
    ovr_ba_set = 1'b0;
    case (ba_state)
      EMPTY: load_rba = wr_b_ok;
      FULL: begin
        load_rba   = wr_b_ok & rda;
        ovr_ba_set = wr_b_ok & ~rda;
      end
    endcase
  end

  // Data registers and sticky overrun bits; a new overrun wins over clrov.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rab   <= '0;
      rba   <= '0;
      ovr_q <= 2'b00;
    end else begin
      if (load_rab) rab <= a;
      if (load_rba) rba <= b;
      ovr_q[0] <= ovr_ab_set | (ovr_q[0] & ~clrov);
      ovr_q[1] <= ovr_ba_set | (ovr_q[1] & ~clrov);
    end
  end

  assign fab = (ab_state == FULL);
  assign fba = (ba_state == FULL);
  assign ovr = ovr_q;

  // Bus drivers depend only on the enables, never on the flags or reset.
  assign b = oeb_ ? {WIDTH{1'bz}} : rab;
  assign a = oea_ ? {WIDTH{1'bz}} : rba;

`ifdef AM2950_PORT_INT_EN
  // Interrupt requests: unread data or an overrun pending toward each side.
  assign inta_ = ~(fba | ovr_q[1]);
  assign intb_ = ~(fab | ovr_q[0]);
`endif

endmodule

// File: tb/tb_am2950_port.sv
// tb_am2950_port: directed bench for am2950_port with an expected-value queue.
// Both buses carry pull-ups, so an undriven bus reads all ones.
module tb_am2950_port;

  logic       clk;
  logic       rst_;
  logic       wra, rdb, wrb, rda;
  logic       oea_, oeb_;
  logic       clrov;
  logic       fab, fba;
  logic [1:0] ovr;
`ifdef AM2950_PORT_INT_EN
  logic       inta_, intb_;
`endif

  logic [7:0] a_drv, b_drv;
  logic       a_en, b_en;
  wire  [7:0] a;
  wire  [7:0] b;

  assign a = a_en ? a_drv : 8'hzz;
  assign b = b_en ? b_drv : 8'hzz;
  pullup (a);
  pullup (b);

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  am2950_port #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_  (rst_),
    .a     (a),
    .b     (b),
    .wra   (wra),
    .rdb   (rdb),
    .wrb   (wrb),
    .rda   (rda),
    .oea_  (oea_),
    .oeb_  (oeb_),
    .fab   (fab),
    .fba   (fba),
    .ovr   (ovr),
    .clrov (clrov)
`ifdef AM2950_PORT_INT_EN
    ,
    .inta_ (inta_),
    .intb_ (intb_)
`endif
  );

  // Clock and reset block: 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to one time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [7:0] e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  initial begin
    rst_ = 1'b0;
    wra = 0; rdb = 0; wrb = 0; rda = 0; clrov = 0;
    oea_ = 1'b0; oeb_ = 1'b0;
    a_en = 0; b_en = 0; a_drv = 8'h00; b_drv = 8'h00;

    // Reset state; enabled buses drive zeros during reset.
    #12;
    sb_push(8'h00); chk("rst_fab", {7'b0, fab});
    sb_push(8'h00); chk("rst_fba", {7'b0, fba});
    sb_push(8'h00); chk("rst_ovr", {6'b0, ovr});
    sb_push(8'h00); chk("rst_a_drive", a);
    sb_push(8'h00); chk("rst_b_drive", b);
    oea_ = 1'b1; oeb_ = 1'b1;
    #1;
    sb_push(8'hFF); chk("rst_a_hiz", a);
    sb_push(8'hFF); chk("rst_b_hiz", b);
    rst_ = 1'b1;
    step();

    // A to B load, then read acknowledge.
    a_en = 1; a_drv = 8'h5A; wra = 1; oeb_ = 1'b0;
    sb_push(8'h01); sb_push(8'h5A);
    step(); wra = 0;
    chk("t1_fab", {7'b0, fab});
    chk("t1_b", b);
    rdb = 1;
    sb_push(8'h00); sb_push(8'h5A);
    step(); rdb = 0;
    chk("t1_fab_rd", {7'b0, fab});
    chk("t1_b_hold", b);

    // Overrun on A to B, then clear.
    a_drv = 8'h11; wra = 1;
    sb_push(8'h01); sb_push(8'h11); sb_push(8'h00);
    step(); wra = 0;
    chk("t2_fab", {7'b0, fab});
    chk("t2_b", b);
    chk("t2_ovr0", {6'b0, ovr});
    a_drv = 8'h22; wra = 1;
    sb_push(8'h11); sb_push(8'h01); sb_push(8'h01);
    step(); wra = 0;
    chk("t2_b_keep", b);
    chk("t2_fab_keep", {7'b0, fab});
    chk("t2_ovr_set", {6'b0, ovr});
    clrov = 1;
    sb_push(8'h00); sb_push(8'h01);
    step(); clrov = 0;
    chk("t2_ovr_clr", {6'b0, ovr});
    chk("t2_fab_clr", {7'b0, fab});

    // Simultaneous write and read while FULL: read goes first.
    a_drv = 8'h33; wra = 1; rdb = 1;
    sb_push(8'h33); sb_push(8'h01); sb_push(8'h00);
    step(); wra = 0; rdb = 0;
    chk("t3_b", b);
    chk("t3_fab", {7'b0, fab});
    chk("t3_ovr", {6'b0, ovr});
    rdb = 1;
    sb_push(8'h00);
    step();
    chk("t3_fab_rd", {7'b0, fab});
    // Read acknowledge while EMPTY is a no-op.
    sb_push(8'h00); sb_push(8'h33);
    step(); rdb = 0;
    chk("t3_rd_empty", {7'b0, fab});
    chk("t3_b_empty", b);

    // Overrun takes priority over a same-edge clrov.
    a_drv = 8'h44; wra = 1;
    step();
    a_drv = 8'h55; clrov = 1;
    sb_push(8'h01); sb_push(8'h44);
    step(); wra = 0; clrov = 0;
    chk("t3_ovr_prio", {6'b0, ovr});
    chk("t3_b_prio", b);
    clrov = 1; rdb = 1;
    sb_push(8'h00); sb_push(8'h00);
    step(); clrov = 0; rdb = 0;
    chk("t3_ovr_clr2", {6'b0, ovr});
    chk("t3_fab_clr2", {7'b0, fab});

    // B to A load; wra ignored while A is driven.
    a_en = 0; oeb_ = 1'b1;
    #1;
    b_en = 1; b_drv = 8'hC3; wrb = 1;
    sb_push(8'h01);
    step(); wrb = 0; b_en = 0;
    chk("t4_fba", {7'b0, fba});
    oea_ = 1'b0;
    #1;
    sb_push(8'hC3); chk("t4_a", a);
    wra = 1;
    sb_push(8'h00); sb_push(8'hC3);
    step(); wra = 0;
    chk("t4_fab_ign", {7'b0, fab});
    chk("t4_a_hold", a);
    oea_ = 1'b1; rda = 1;
    sb_push(8'h00);
    step(); rda = 0;
    chk("t4_fba_rd", {7'b0, fba});

    // B to A overrun.
    b_en = 1; b_drv = 8'hD1; wrb = 1;
    step();
    b_drv = 8'hE2;
    sb_push(8'h01); sb_push(8'h02);
    step(); wrb = 0; b_en = 0;
    chk("t4_fba_ovr", {7'b0, fba});
    chk("t4_ovr1", {6'b0, ovr});
    oea_ = 1'b0;
    #1;
    sb_push(8'hD1); chk("t4_a_keep", a);
    oea_ = 1'b1; rda = 1; clrov = 1;
    sb_push(8'h00); sb_push(8'h00);
    step(); rda = 0; clrov = 0;
    chk("t4_fba_clr", {7'b0, fba});
    chk("t4_ovr_clr", {6'b0, ovr});

    // Both FULL plus an overrun, then asynchronous reset mid-cycle.
    a_en = 1; a_drv = 8'h77; wra = 1;
    b_en = 1; b_drv = 8'h88; wrb = 1;
    sb_push(8'h01); sb_push(8'h01);
    step(); wrb = 0; b_en = 0;
    chk("t5_fab", {7'b0, fab});
    chk("t5_fba", {7'b0, fba});
    a_drv = 8'h78;
    sb_push(8'h01);
    step(); wra = 0; a_en = 0;
    chk("t5_ovr", {6'b0, ovr});
    #2;
    rst_ = 1'b0;
    #1;
    sb_push(8'h00); chk("t5_rst_fab", {7'b0, fab});
    sb_push(8'h00); chk("t5_rst_fba", {7'b0, fba});
    sb_push(8'h00); chk("t5_rst_ovr", {6'b0, ovr});
    sb_push(8'hFF); chk("t5_rst_a_hiz", a);
    sb_push(8'hFF); chk("t5_rst_b_hiz", b);
    oea_ = 1'b0; oeb_ = 1'b0;
    #1;
    sb_push(8'h00); chk("t5_rst_a_zero", a);
    sb_push(8'h00); chk("t5_rst_b_zero", b);
    oea_ = 1'b1; oeb_ = 1'b1;
    #1;
    // A strobe during reset is discarded.
    a_en = 1; a_drv = 8'h99; wra = 1;
    sb_push(8'h00);
    step();
    chk("t5_rst_strobe", {7'b0, fab});
    wra = 0; rst_ = 1'b1;
    sb_push(8'h00);
    step();
    chk("t5_post_rst", {7'b0, fab});
    a_drv = 8'hAB; wra = 1;
    step(); wra = 0; a_en = 0; oeb_ = 1'b0;
    #1;
    sb_push(8'h01); chk("t5_first_fab", {7'b0, fab});
    sb_push(8'hAB); chk("t5_first_b", b);
    sb_push(8'h00); chk("t5_first_ovr", {6'b0, ovr});

    // Interrupt outputs follow the B to A flag.
    rdb = 1; oeb_ = 1'b1;
    sb_push(8'h00);
    step(); rdb = 0;
    chk("t6_fab_clr", {7'b0, fab});
    b_en = 1; b_drv = 8'h5C; wrb = 1;
    sb_push(8'h01);
    step(); wrb = 0; b_en = 0;
    chk("t6_fba", {7'b0, fba});
`ifdef AM2950_PORT_INT_EN
    sb_push(8'h01); chk("t6_intb_", {7'b0, intb_});
    sb_push(8'h00); chk("t6_inta_", {7'b0, inta_});
`endif
    rda = 1;
    sb_push(8'h00);
    step(); rda = 0;
    chk("t6_fba_rd", {7'b0, fba});
`ifdef AM2950_PORT_INT_EN
    sb_push(8'h01); chk("t6_inta_rd", {7'b0, inta_});
`endif

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
